// File: rtl/fp16_pkg.sv
// Shared binary16 constants and the divider state type.
package fp16_pkg;

    localparam int EXP_BIAS = 15;
    localparam int EXP_MAX  = 31;
    localparam int MANT_W   = 10;

    localparam logic [15:0] POS_INF = 16'h7C00;
    localparam logic [15:0] NEG_INF = 16'hFC00;
    localparam logic [15:0] QNAN    = 16'h7E00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV   = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fp16div_round.sv
// Normalise, round and range-check a 13-bit restoring-division quotient into
// a packed binary16 value. Purely combinational.
module fp16div_round
    import fp16_pkg::*;
#(
    parameter bit ROUND_NEAREST = 1'b1
) (
    input  logic [12:0]       q_i,
    input  logic              rem_nz_i,
    input  logic signed [6:0] e_i,
    input  logic              sign_i,
    output logic [15:0]       res_o
);

    localparam logic signed [6:0] E_TOP = 7'(EXP_MAX);

    logic [MANT_W-1:0] mant;
    logic              guard;
    logic              sticky;
    logic              inc;
    logic [MANT_W:0]   mant_sum;
    logic signed [6:0] e_norm;
    logic signed [6:0] e_fin;

    always_comb begin
        if (q_i[12]) begin
            mant   = q_i[11:2];
            guard  = q_i[1];
            sticky = q_i[0] | rem_nz_i;
            e_norm = e_i;
        end else begin
            mant   = q_i[10:1];
            guard  = q_i[0];
            sticky = rem_nz_i;
            e_norm = e_i - 7'sd1;
        end

        inc      = ROUND_NEAREST && guard && (sticky || mant[0]);
        mant_sum = {1'b0, mant} + {{MANT_W{1'b0}}, inc};
        // a carry-out leaves mant_sum[MANT_W-1:0] at zero, which is the wanted mantissa
        e_fin    = e_norm + (mant_sum[MANT_W] ? 7'sd1 : 7'sd0);

        if (e_fin >= E_TOP) begin
            res_o = sign_i ? NEG_INF : POS_INF;
        end else if (e_fin <= 7'sd0) begin
            res_o = {sign_i, 15'h0000};
        end else begin
            res_o = {sign_i, e_fin[4:0], mant_sum[MANT_W-1:0]};
        end
    end

endmodule

// File: rtl/fp16div.sv
// Iterative binary16 divider, one quotient bit per cycle, valid/ready on both sides.
// Optional FP16DIV_NAN_EN: return canonical quiet NaN for NaN, 0/0 and inf/inf operands.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// DIV   | 13 restoring-division iterations, cnt_q 12..0
// ROUND | normalise, round, range-check, register x
// DONE  | out_valid high, x held until out_ready
module fp16div
    import fp16_pkg::*;
#(
    parameter bit ROUND_NEAREST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] x
);

    localparam logic [4:0]        EXP_ONES = 5'(EXP_MAX);
    localparam logic signed [6:0] E_BIAS   = 7'(EXP_BIAS);

    state_t            state_q, state_d;
    logic [10:0]       dvsr_q, dvsr_d;
    logic [11:0]       rem_q, rem_d;
    logic [12:0]       q_q, q_d;
    logic [3:0]        cnt_q, cnt_d;
    logic signed [6:0] e_q, e_d;
    logic              sign_q, sign_d;
    logic [15:0]       x_q, x_d;

    logic [4:0]  ea, eb;
    logic        in_sign;
    logic        nan_case;
    logic        is_special;
    logic [15:0] special_x;
    logic [12:0] trial;
    logic        ge;
    logic [11:0] rem_next;
    logic        rem_nz;
    logic [15:0] round_x;

    always_comb begin
        ea         = a[14:10];
        eb         = b[14:10];
        in_sign    = a[15] ^ b[15];
        nan_case   = 1'b0;
        is_special = 1'b1;
        special_x  = in_sign ? NEG_INF : POS_INF;
`ifdef FP16DIV_NAN_EN
        nan_case = ((ea == EXP_ONES) && (a[9:0] != 10'd0)) ||
                   ((eb == EXP_ONES) && (b[9:0] != 10'd0)) ||
                   ((ea == 5'd0) && (eb == 5'd0)) ||
                   ((ea == EXP_ONES) && (eb == EXP_ONES));
`endif
        if (nan_case) begin
            special_x = QNAN;
        end else if (ea == EXP_ONES || eb == 5'd0) begin
            special_x = in_sign ? NEG_INF : POS_INF;
        end else if (eb == EXP_ONES || ea == 5'd0) begin
            special_x = {in_sign, 15'h0000};
        end else begin
            is_special = 1'b0;
        end
    end

    // Partial remainder is always below 2*divisor, so 12 bits hold it and the
    // 13-bit difference sign tells whether the divisor fits.
    always_comb begin
        trial    = {1'b0, rem_q} - {2'b00, dvsr_q};
        ge       = ~trial[12];
        rem_next = ge ? trial[11:0] : rem_q;
        rem_nz   = (rem_q != 12'd0);
    end

    fp16div_round #(
        .ROUND_NEAREST(ROUND_NEAREST)
    ) u_round (
        .q_i      (q_q),
        .rem_nz_i (rem_nz),
        .e_i      (e_q),
        .sign_i   (sign_q),
        .res_o    (round_x)
    );

    always_comb begin
        state_d = state_q;
        dvsr_d  = dvsr_q;
        rem_d   = rem_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        e_d     = e_q;
        sign_d  = sign_q;
        x_d     = x_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = in_sign;
                    e_d     = $signed({2'b00, ea}) - $signed({2'b00, eb}) + E_BIAS;
                    dvsr_d  = {1'b1, b[9:0]};
                    rem_d   = {2'b01, a[9:0]};
                    q_d     = 13'd0;
                    cnt_d   = 4'd12;
                    if (is_special) begin
                        x_d     = special_x;
                        state_d = DONE;
                    end else begin
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                q_d   = {q_q[11:0], ge};
                rem_d = rem_next << 1;
                if (cnt_q == 4'd0) begin
                    state_d = ROUND;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ROUND: begin
                x_d     = round_x;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            dvsr_q  <= 11'd0;
            rem_q   <= 12'd0;
            q_q     <= 13'd0;
            cnt_q   <= 4'd0;
            e_q     <= 7'sd0;
            sign_q  <= 1'b0;
            x_q     <= 16'h0000;
        end else begin
            state_q <= state_d;
            dvsr_q  <= dvsr_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            e_q     <= e_d;
            sign_q  <= sign_d;
            x_q     <= x_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign x         = x_q;

endmodule
